collision_scheduler: RTL and testbench
======================================

Name: collision_scheduler

Overview:
Per-frame sequencer that time-shares one combinational car/box collision checker across N_OBJ obstacle slots. On each frame_start pulse it snapshots the player car box and reads each obstacle from the object table. It presents each player/obstacle pair to the checker, collects the per-object hit flags, and publishes a hit mask, an any-hit flag and the lowest hit index to game logic with a one-cycle done pulse.

Parameters:
N_OBJ, 8, number of obstacle slots scanned per frame (2..64)
IDX_W, 3, index width, equal to clog2(N_OBJ)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scan permission; low aborts and blocks scans
frame_start  in  1  one-cycle scan request
player_x  in  10  player centre x
player_y  in  9  player centre y
player_w  in  10  player width
player_h  in  9  player height
obj_rd  out  1  object table read strobe
obj_addr  out  IDX_W  object table address
obj_data  in  38  {x[9:0],y[8:0],w[9:0],h[8:0]}, valid exactly 1 cycle after obj_rd
obj_active  in  1  slot-occupied flag, same timing as obj_data
cmp_x1  out  10  checker box 1 (player) x
cmp_y1  out  9  checker box 1 y
cmp_w1  out  10  checker box 1 w
cmp_h1  out  9  checker box 1 h
cmp_x2  out  10  checker box 2 (obstacle) x
cmp_y2  out  9  checker box 2 y
cmp_w2  out  10  checker box 2 w
cmp_h2  out  9  checker box 2 h
cmp_hit  in  1  checker result (combinational from cmp_*)
busy  out  1  scan in progress
done  out  1  one-cycle pulse when results are updated
hit_mask  out  N_OBJ  bit i set = obstacle i collided this frame
any_hit  out  1  OR of hit_mask
first_hit_idx  out  IDX_W  lowest set index of hit_mask; 0 when none
overrun  out  1  one-cycle pulse when frame_start is ignored because a scan is in progress

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0, including the cmp_* registers, hit_mask, obj_addr and the pulses. Reset mid-scan discards the partial results.
- States: IDLE, FETCH, LATCH, EVAL, DONE. busy is high in FETCH, LATCH, EVAL and DONE.
- IDLE: frame_start & enable -> snapshot player_* into cmp_*1 registers, clear the working mask, idx=0, go to FETCH. frame_start with enable low: ignored, no overrun pulse.
- FETCH: obj_rd=1 and obj_addr=idx for this cycle only, then go to LATCH.
- LATCH: register obj_data into cmp_*2 and register obj_active. Go to EVAL.
- EVAL: working_mask[idx] = cmp_hit & active_q. An inactive slot yields 0 regardless of cmp_hit. If idx==N_OBJ-1, go to DONE; else idx+1 and go to FETCH.
- DONE: copy working_mask to hit_mask and update any_hit and first_hit_idx (priority: lowest index). done=1 for this cycle. Go to IDLE.
- Latency: frame_start sampled at edge k gives FETCH(0) in cycle k+1, DONE in cycle k+3*N_OBJ+1 (k+25 at default). A new frame_start is accepted the cycle after DONE.
- frame_start in any busy state, including DONE: ignored; overrun pulses for 1 cycle.
- enable low in any busy state: return to IDLE next edge. No done; hit_mask, any_hit and first_hit_idx keep their previous values; busy falls.
- Results hold stable between done pulses. cmp_*1 is held for the whole scan; player_* changes mid-scan have no effect.
- Arithmetic: idx counter is IDX_W bits; no wrap is reachable because the terminal compare is against N_OBJ-1. No coordinate arithmetic is done here; the checker owns edge clamping.
- done and overrun never assert in the same cycle except when frame_start arrives during DONE (both high).

Decomposition:
- Shared package (race_pkg): X_W=10, Y_W=9, OBJ_DATA_W=38, field slice offsets for obj_data, and the scheduler state enum.
- One natural sub-module: hit_priority_enc (N_OBJ mask -> any, lowest index).
- The collision checker is instantiated beside this block and wired through cmp_*/cmp_hit.

Test Plan:
- Player (320,400,40,60); slot2 = (330,380,40,60) active; all others at (100,100,20,20) active. frame_start at k -> done at k+25, hit_mask=8'b00000100, any_hit=1, first_hit_idx=2.
- Slots 3 and 6 both overlapping the player, slot 3 obj_active=0 -> hit_mask=8'b01000000, first_hit_idx=6.
- No overlaps -> hit_mask=0, any_hit=0, first_hit_idx=0, done pulses once.
- frame_start again at k+10 during a scan -> overrun pulse at k+10, single done at k+25. frame_start at k+26 -> accepted, next done at k+51.
- enable dropped at k+12 -> busy=0 at k+13, no done, previous hit_mask retained. rst_n low at k+5 of a fresh scan -> all outputs 0 immediately (asynchronously).
- player_x changed to 0 at k+8 -> result identical to the first scenario (snapshot); obj_rd high exactly once per slot, obj_addr 0..7 in order.

Source files
------------

// File: rtl/race_pkg.sv
// Shared types and constants for the race-game collision path: coordinate
// widths, the object-table word layout and the scheduler state encoding.
package race_pkg;

   localparam int X_W        = 10;
   localparam int Y_W        = 9;
   localparam int OBJ_DATA_W = 38;

   // Object-table word is {x[9:0], y[8:0], w[9:0], h[8:0]}, MSB first.
   localparam int OBJ_X_LSB = 28;
   localparam int OBJ_Y_LSB = 19;
   localparam int OBJ_W_LSB = 9;
   localparam int OBJ_H_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LATCH,
      ST_EVAL,
      ST_DONE
   } sched_state_e;

   // Centre-based axis-aligned box as the checker sees it.
   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic [X_W-1:0] w;
      logic [Y_W-1:0] h;
   } box_t;

   // Split a raw object-table word into its box fields.
   function automatic box_t unpack_box(input logic [OBJ_DATA_W-1:0] d);
      box_t b;
      b.x = d[OBJ_X_LSB +: X_W];
      b.y = d[OBJ_Y_LSB +: Y_W];
      b.w = d[OBJ_W_LSB +: X_W];
      b.h = d[OBJ_H_LSB +: Y_W];
      return b;
   endfunction

endpackage

// File: rtl/collision_scheduler_hit_priority_enc.sv
// Reduces a per-object hit mask to an any-hit flag and the lowest set index.
module hit_priority_enc #(
   parameter int N_OBJ = 8,
   parameter int IDX_W = 3
) (
   input  logic [N_OBJ-1:0] mask,
   output logic             any_hit,
   output logic [IDX_W-1:0] first_idx
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      any_hit   = |mask;
      first_idx = '0;
      for (int i = N_OBJ - 1; i >= 0; i--) begin
         if (mask[i]) first_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/collision_scheduler.sv
// Per-frame sequencer that time-shares one combinational box checker across
// all obstacle slots and publishes the frame's hit mask with a done pulse.
module collision_scheduler
   import race_pkg::*;
#(
   parameter int N_OBJ = 8,
   parameter int IDX_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  frame_start,
   input  logic [X_W-1:0]        player_x,
   input  logic [Y_W-1:0]        player_y,
   input  logic [X_W-1:0]        player_w,
   input  logic [Y_W-1:0]        player_h,
   output logic                  obj_rd,
   output logic [IDX_W-1:0]      obj_addr,
   input  logic [OBJ_DATA_W-1:0] obj_data,
   input  logic                  obj_active,
   output logic [X_W-1:0]        cmp_x1,
   output logic [Y_W-1:0]        cmp_y1,
   output logic [X_W-1:0]        cmp_w1,
   output logic [Y_W-1:0]        cmp_h1,
   output logic [X_W-1:0]        cmp_x2,
   output logic [Y_W-1:0]        cmp_y2,
   output logic [X_W-1:0]        cmp_w2,
   output logic [Y_W-1:0]        cmp_h2,
   input  logic                  cmp_hit,
   output logic                  busy,
   output logic                  done,
   output logic [N_OBJ-1:0]      hit_mask,
   output logic                  any_hit,
   output logic [IDX_W-1:0]      first_hit_idx,
   output logic                  overrun
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);

   sched_state_e     state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   box_t             player_q, player_d;
   box_t             obst_q, obst_d;
   logic             active_q, active_d;
   logic [N_OBJ-1:0] work_mask_q, work_mask_d;
   logic [N_OBJ-1:0] hit_mask_q, hit_mask_d;
   logic             accept;

   assign accept = (state_q == ST_IDLE) && frame_start && enable;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; dropping enable aborts any scan back to idle.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (accept) state_d = ST_FETCH;
         ST_FETCH: state_d = ST_LATCH;
         ST_LATCH: state_d = ST_EVAL;
         ST_EVAL:  state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_FETCH;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (state_q != ST_IDLE && !enable) state_d = ST_IDLE;
   end

   // Moore outputs decoded from the current state, plus the overrun flag.
   always_comb begin
      obj_rd   = (state_q == ST_FETCH);
      obj_addr = (state_q == ST_FETCH) ? idx_q : '0;
      busy     = (state_q != ST_IDLE);
      done     = (state_q == ST_DONE);
      overrun  = (state_q != ST_IDLE) && frame_start;
   end

   // Datapath: snapshot the player, latch each obstacle, collect hit bits.
   // Results are copied on the edge into DONE so they are valid while done
   // is high; an abort on that edge leaves the old results untouched.
   always_comb begin
      idx_d       = idx_q;
      player_d    = player_q;
      obst_d      = obst_q;
      active_d    = active_q;
      work_mask_d = work_mask_q;
      hit_mask_d  = hit_mask_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               player_d    = '{x: player_x, y: player_y, w: player_w, h: player_h};
               work_mask_d = '0;
               idx_d       = '0;
            end
         end
         ST_LATCH: begin
            obst_d   = unpack_box(obj_data);
            active_d = obj_active;
         end
         ST_EVAL: begin
            work_mask_d[idx_q] = cmp_hit & active_q;
            if (idx_q != LAST_IDX)  idx_d      = idx_q + IDX_W'(1);
            else if (enable)        hit_mask_d = work_mask_d;
         end
         default: ;
      endcase
   end

   // Datapath registers.
   // NOTE: all of these are plain flops, so each one is cleared on reset;
   // a reset mid-scan therefore also discards the partial mask.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         player_q    <= '0;
         obst_q      <= '0;
         active_q    <= 1'b0;
         work_mask_q <= '0;
         hit_mask_q  <= '0;
      end else begin
         idx_q       <= idx_d;
         player_q    <= player_d;
         obst_q      <= obst_d;
         active_q    <= active_d;
         work_mask_q <= work_mask_d;
         hit_mask_q  <= hit_mask_d;
      end
   end

   assign cmp_x1   = player_q.x;
   assign cmp_y1   = player_q.y;
   assign cmp_w1   = player_q.w;
   assign cmp_h1   = player_q.h;
   assign cmp_x2   = obst_q.x;
   assign cmp_y2   = obst_q.y;
   assign cmp_w2   = obst_q.w;
   assign cmp_h2   = obst_q.h;
   assign hit_mask = hit_mask_q;

   hit_priority_enc #(
      .N_OBJ(N_OBJ),
      .IDX_W(IDX_W)
   ) u_hit_priority_enc (
      .mask     (hit_mask_q),
      .any_hit  (any_hit),
      .first_idx(first_hit_idx)
   );

endmodule

// File: tb/tb_collision_scheduler.sv
// Self-checking bench for collision_scheduler: object table, box checker and
// a frame-level reference model, plus directed scenarios with literal results.
module tb_collision_scheduler;

   localparam int N_OBJ = 8;
   localparam int IDX_W = 3;

   logic             clk, rst_n, enable, frame_start;
   logic [9:0]       player_x, player_w;
   logic [8:0]       player_y, player_h;
   logic             obj_rd;
   logic [IDX_W-1:0] obj_addr;
   logic [37:0]      obj_data;
   logic             obj_active;
   logic [9:0]       cmp_x1, cmp_w1, cmp_x2, cmp_w2;
   logic [8:0]       cmp_y1, cmp_h1, cmp_y2, cmp_h2;
   logic             cmp_hit;
   logic             busy, done, any_hit, overrun;
   logic [N_OBJ-1:0] hit_mask;
   logic [IDX_W-1:0] first_hit_idx;

   collision_scheduler #(.N_OBJ(N_OBJ), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
      .player_x(player_x), .player_y(player_y), .player_w(player_w), .player_h(player_h),
      .obj_rd(obj_rd), .obj_addr(obj_addr), .obj_data(obj_data), .obj_active(obj_active),
      .cmp_x1(cmp_x1), .cmp_y1(cmp_y1), .cmp_w1(cmp_w1), .cmp_h1(cmp_h1),
      .cmp_x2(cmp_x2), .cmp_y2(cmp_y2), .cmp_w2(cmp_w2), .cmp_h2(cmp_h2),
      .cmp_hit(cmp_hit), .busy(busy), .done(done), .hit_mask(hit_mask),
      .any_hit(any_hit), .first_hit_idx(first_hit_idx), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;   // rising edges seen out of reset

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
   endtask

   // Centre-based overlap: boxes touch when twice the centre distance is
   // below the summed extents on both axes.
   function automatic bit overlap(input int ax, ay, aw, ah, bx, by, bw, bh);
      int dx, dy;
      dx = (ax > bx) ? ax - bx : bx - ax;
      dy = (ay > by) ? ay - by : by - ay;
      return (2 * dx < aw + bw) && (2 * dy < ah + bh);
   endfunction

   assign cmp_hit = overlap(cmp_x1, cmp_y1, cmp_w1, cmp_h1, cmp_x2, cmp_y2, cmp_w2, cmp_h2);

   // Object table contents.
   int tx[N_OBJ], ty[N_OBJ], tw[N_OBJ], th[N_OBJ];
   bit tact[N_OBJ];

   // Table read port: data appears one cycle after a strobe, zero otherwise.
   bit rd_pend;
   int rd_addr;
   int rd_count;
   int rd_log[16];
   always @(negedge clk) begin
      rd_pend = obj_rd;
      rd_addr = int'(obj_addr);
      if (obj_rd && rd_count < 16) begin
         rd_log[rd_count] = int'(obj_addr);
         rd_count++;
      end
   end
   always @(posedge clk) begin
      #1;
      if (rd_pend) begin
         obj_data   = {10'(tx[rd_addr]), 9'(ty[rd_addr]), 10'(tw[rd_addr]), 9'(th[rd_addr])};
         obj_active = tact[rd_addr];
      end else begin
         obj_data   = '0;
         obj_active = 1'b0;
      end
   end

   // Frame-level model: an accepted frame is busy for 25 cycles, reads slot i
   // at offset 3i, publishes its mask on entering the last cycle.
   bit         m_busy;
   int         m_start;
   logic [7:0] m_exp, m_pub;
   int         sx, sy, sw, sh;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_pub = '0; m_exp = '0;
         sx = 0; sy = 0; sw = 0; sh = 0;
      end else begin
         cyc++;
         if (m_busy) begin
            if (!enable)                 m_busy = 0;
            else if (cyc == m_start + 24) m_pub = m_exp;
            else if (cyc == m_start + 25) m_busy = 0;
         end else if (frame_start && enable) begin
            m_busy = 1; m_start = cyc;
            sx = player_x; sy = player_y; sw = player_w; sh = player_h;
            for (int i = 0; i < N_OBJ; i++)
               m_exp[i] = tact[i] && overlap(sx, sy, sw, sh, tx[i], ty[i], tw[i], th[i]);
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      int t, e_first;
      bit e_rd;
      t    = cyc - m_start;
      e_rd = m_busy && t <= 21 && (t % 3) == 0;
      e_first = 0;
      for (int i = N_OBJ - 1; i >= 0; i--) if (m_pub[i]) e_first = i;
      check("busy", busy, m_busy);
      check("done", done, m_busy && t == 24);
      check("overrun", overrun, m_busy && frame_start);
      check("obj_rd", obj_rd, e_rd);
      check("obj_addr", obj_addr, e_rd ? t / 3 : 0);
      check("hit_mask", hit_mask, m_pub);
      check("any_hit", any_hit, |m_pub);
      check("first_hit_idx", first_hit_idx, e_first);
      check("cmp1", {cmp_x1, cmp_y1, cmp_w1, cmp_h1}, {10'(sx), 9'(sy), 10'(sw), 9'(sh)});
      if (m_busy && t <= 23 && (t % 3) == 2)
         check("cmp2", {cmp_x2, cmp_y2, cmp_w2, cmp_h2},
               {10'(tx[t/3]), 9'(ty[t/3]), 10'(tw[t/3]), 9'(th[t/3])});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_edge(input int target);
      while (cyc < target) tick();
   endtask

   // Returns the edge at which the request was sampled.
   task automatic start_frame(output int k);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      k = cyc;
   endtask

   // Waits for done; reports its cycle number relative to the request edge.
   task automatic wait_done(input int k, input string name);
      int lat = -1;
      for (int n = 0; n < 40 && lat < 0; n++) begin
         tick();
         if (done) lat = cyc + 1 - k;
      end
      check(name, lat, 25);
   endtask

   task automatic set_bg();
      for (int i = 0; i < N_OBJ; i++) begin
         tx[i] = 100; ty[i] = 100; tw[i] = 20; th[i] = 20; tact[i] = 1;
      end
   endtask

   task automatic set_hit_slot(input int i);
      tx[i] = 330; ty[i] = 380; tw[i] = 40; th[i] = 60;
   endtask

   task automatic check_result(input string name, input logic [7:0] mask, input int first);
      check({name, "_mask"}, hit_mask, mask);
      check({name, "_any"}, any_hit, mask != 0);
      check({name, "_first"}, first_hit_idx, first);
   endtask

   initial begin
      int k, k2, nd;
      rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0;
      player_x = 10'd320; player_y = 9'd400; player_w = 10'd40; player_h = 9'd60;
      obj_data = '0; obj_active = 1'b0; rd_count = 0;
      set_bg();
      #2;
      check("reset_busy", busy, 0);
      check("reset_mask", hit_mask, 0);
      check("reset_cmp_x1", cmp_x1, 0);
      check("reset_obj_rd", obj_rd, 0);
      tick(); tick();
      rst_n = 1'b1; enable = 1'b1;
      tick();

      // Single hit in slot 2; every slot read once in order.
      set_hit_slot(2);
      rd_count = 0;
      start_frame(k);
      wait_done(k, "s1_done_cycle");
      check_result("s1", 8'b0000_0100, 2);
      check("s1_rd_count", rd_count, 8);
      for (int i = 0; i < N_OBJ; i++) check("s1_rd_order", rd_log[i], i);
      tick();

      // Player moves mid-scan: snapshot keeps the original box.
      start_frame(k);
      wait_edge(k + 7);
      player_x = 10'd0;
      wait_done(k, "s6_done_cycle");
      check_result("s6", 8'b0000_0100, 2);
      player_x = 10'd320;
      tick();

      // Overrun mid-scan, again during DONE, then back-to-back accept.
      start_frame(k);
      wait_edge(k + 9);
      frame_start = 1'b1;
      #1 check("s4_overrun", overrun, 1);
      tick();
      frame_start = 1'b0;
      wait_done(k, "s4_done_cycle");
      frame_start = 1'b1;
      #1 check("s4_done_and_overrun", {done, overrun}, 2'b11);
      tick();
      frame_start = 1'b0;
      start_frame(k2);
      check("s4_accept_edge", k2 - k, 26);
      wait_done(k2, "s4_second_done");
      tick();

      // Abort via enable: busy falls, no done, old result kept.
      start_frame(k);
      wait_edge(k + 11);
      enable = 1'b0;
      tick();
      check("s5_busy_fall", busy, 0);
      check("s5_mask_kept", hit_mask, 8'b0000_0100);
      frame_start = 1'b1;
      #1 check("s5_disabled_no_overrun", overrun, 0);
      tick();
      frame_start = 1'b0;
      check("s5_disabled_ignored", busy, 0);
      nd = 0;
      repeat (30) begin tick(); if (done) nd++; end
      check("s5_no_done", nd, 0);
      enable = 1'b1;
      tick();

      // Asynchronous reset mid-scan clears everything at once.
      start_frame(k);
      wait_edge(k + 4);
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_mask", hit_mask, 0);
      check("rst_cmp1", {cmp_x1, cmp_w1}, 0);
      check("rst_obj_rd", obj_rd, 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Two overlapping slots, the lower one inactive.
      set_bg(); set_hit_slot(3); set_hit_slot(6); tact[3] = 0;
      start_frame(k);
      wait_done(k, "s2_done_cycle");
      check_result("s2", 8'b0100_0000, 6);
      tick();

      // No overlaps.
      set_bg();
      start_frame(k);
      wait_done(k, "s3_done_cycle");
      check_result("s3", 8'b0000_0000, 0);
      tick();

      // First and last slot both hit.
      set_bg(); set_hit_slot(0); set_hit_slot(7);
      start_frame(k);
      wait_done(k, "s7_done_cycle");
      check_result("s7", 8'b1000_0001, 0);
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
